log_dump_encoder: RTL
=====================

Name: log_dump_encoder

Overview:
- Transmit-side counterpart of the ASCII command decoder.
- On a DUMP request, drains captured samples from the logger FIFO and encodes each one as ASCII hex text.
- Presents the text byte-by-byte to the UART transmitter over a valid/ready handshake.
- Sits between the sample FIFO read port and the UART TX byte interface; driven by the logger FSM.

Parameters:
- SAMPLE_W, 8, sample width in bits; must be a multiple of 4; hex chars per sample NCH = SAMPLE_W/4.
- LINE_LEN, 16, samples per text line before CR LF is inserted; valid range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dump_start  in  1  single-cycle pulse from logger FSM on entry to DUMP
- abort  in  1  stop dump at next byte boundary (CLEAR/STOP)
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe, one cycle per sample
- fifo_rd_data  in  SAMPLE_W  FIFO data, valid exactly 1 cycle after fifo_rd_en
- tx_data  out  8  ASCII byte to UART TX (byte_t)
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- busy  out  1  dump in progress
- done  out  1  single-cycle pulse when dump completes or aborts

Behaviour:
- Reset: all outputs 0; FSM in IDLE; line and nibble counters cleared. Reset mid-dump takes effect immediately; no partial byte is completed.
- FSM states and transitions:
  - IDLE: on dump_start go to FETCH; busy=1 from the next cycle.
  - FETCH: if !fifo_empty, assert fifo_rd_en for 1 cycle and go to CAPTURE. Else, if line count > 0 or no sample has been sent yet, go to CR; otherwise go to FINISH.
  - CAPTURE: latch fifo_rd_data into a shift register; go to HEX.
  - HEX: emit NCH nibbles, MSB first. Encoding: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase). After the last nibble, increment the line count. If the line is full (line count == LINE_LEN), go to CR. Else, if !fifo_empty, go to SEP; else go to CR.
  - SEP: emit 0x20 (space), then go to FETCH.
  - CR: emit 0x0D. LF: emit 0x0A, clear line count; if !fifo_empty go to FETCH, else go to FINISH.
  - FINISH: pulse done for 1 cycle, busy=0, go to IDLE.
- Handshake:
  - Each emitting state drives tx_valid=1 with tx_data stable until the cycle where tx_valid && tx_ready; the state advances on that cycle.
  - tx_valid does not depend combinationally on tx_ready.
  - tx_valid is never asserted in IDLE, FETCH, CAPTURE or FINISH.
- Throughput: with tx_ready tied high, at most 2 non-emitting cycles (FETCH, CAPTURE) per sample.
- FIFO usage: fifo_rd_en is never asserted while fifo_empty=1; exactly one read per emitted sample; no read-ahead.
- Empty FIFO at dump_start: output is exactly 0x0D 0x0A, then done.
- Samples arriving during a dump are included, since fifo_empty is re-sampled in FETCH and LF.
- dump_start while busy: ignored.
- abort:
  - If tx_valid=0, go to FINISH next cycle.
  - If tx_valid=1, complete the current handshake, then go to FINISH; no CR LF is appended.
  - abort and dump_start in the same IDLE cycle: abort wins; no dump starts, no done pulse.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - A per-line SAMPLE_W-bit XOR accumulator, cleared at LF and at dump start, folds in each sample at CAPTURE.
  - Before CR on every line that holds ≥1 sample, emit 0x2A ('*') followed by the accumulator as NCH uppercase hex chars.
  - Lines with zero samples carry no checksum.
- Undefined: no accumulator, no '*' or checksum bytes; byte stream exactly as above.

Test Plan:
- Reset asserted mid-dump with tx_valid=1 -> tx_valid, fifo_rd_en, busy, done all 0 within the same cycle; after release, IDLE and no output until the next dump_start.
- FIFO {0x3A,0x05}, tx_ready=1 -> bytes 0x33 0x41 0x20 0x30 0x35 0x0D 0x0A; exactly 2 fifo_rd_en pulses; one done pulse; busy low after.
- FIFO 0x00..0x10 (17 samples), LINE_LEN=16 -> "00 01 … 0F" CR LF "10" CR LF; no trailing space before any CR.
- Same FIFO as test 2, tx_ready random 30% duty -> identical 7-byte sequence; tx_data stable while tx_valid&&!tx_ready; no byte dropped or duplicated.
- Empty FIFO, dump_start -> 0x0D 0x0A then done. Separately: abort during the 2nd sample's first nibble with tx_ready=0 -> that nibble completes on tx_ready, then done, no CR LF.
- DUMP_CHECKSUM_EN defined, FIFO {0x3A,0x05} -> "3A 05*3F" CR LF, i.e. 0x33 0x41 0x20 0x30 0x35 0x2A 0x33 0x46 0x0D 0x0A.

Source files
------------

// File: rtl/log_dump_encoder.sv
// Drains logger FIFO samples on a DUMP request and streams them as ASCII hex lines to UART TX.
// Optional DUMP_CHECKSUM_EN appends '*' plus a per-line XOR checksum before each CR.
module log_dump_encoder #(
    parameter int SAMPLE_W = 8,
    parameter int LINE_LEN = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dump_start,
    input  logic                abort,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [SAMPLE_W-1:0] fifo_rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done
);

    typedef logic [7:0] byte_t;

    localparam int NCH = SAMPLE_W / 4;

    typedef enum logic [3:0] {
        IDLE, FETCH, CAPTURE, HEX, SEP, STAR, CHK, CR, LF, FINISH
    } state_t;

`ifdef DUMP_CHECKSUM_EN
    localparam state_t EOL = STAR;
`else
    localparam state_t EOL = CR;
`endif

    state_t              state, state_n;
    logic [SAMPLE_W-1:0] shreg, shreg_n;
    logic [7:0]          nib_cnt, nib_n;
    logic [7:0]          line_cnt, line_n;
    logic                sent, sent_n;
    logic                abort_pend, pend_n;
    logic                valid_n, busy_n, done_n;
    byte_t               data_n;
    logic                hs, abt, last_nib, line_full;
`ifdef DUMP_CHECKSUM_EN
    logic [SAMPLE_W-1:0] acc, acc_n;
`endif

    function automatic byte_t hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign hs        = tx_valid & tx_ready;
    assign abt       = abort | abort_pend;
    assign last_nib  = (nib_cnt == 8'(NCH - 1));
    assign line_full = ((line_cnt + 8'd1) == 8'(LINE_LEN));

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        nib_n      = nib_cnt;
        line_n     = line_cnt;
        sent_n     = sent;
        pend_n     = abort_pend;
        fifo_rd_en = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        acc_n      = acc;
`endif
        if (abort && state != IDLE && state != FINISH)
            pend_n = 1'b1;
        unique case (state)
            IDLE: begin
                // abort in the same cycle cancels the request outright
                if (dump_start && !abort) begin
                    state_n = FETCH;
                    line_n  = 8'd0;
                    nib_n   = 8'd0;
                    sent_n  = 1'b0;
                    pend_n  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
                    acc_n   = '0;
`endif
                end
            end
            FETCH: begin
                if (abt)
                    state_n = FINISH;
                else if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_n    = CAPTURE;
                end else if (line_cnt != 8'd0)
                    state_n = EOL;
                else if (!sent)
                    state_n = CR;
                else
                    state_n = FINISH;
            end
            CAPTURE: begin
                if (abt)
                    state_n = FINISH;
                else begin
                    shreg_n = fifo_rd_data;
                    nib_n   = 8'd0;
                    sent_n  = 1'b1;
                    state_n = HEX;
`ifdef DUMP_CHECKSUM_EN
                    acc_n   = acc ^ fifo_rd_data;
`endif
                end
            end
            HEX: begin
                if (hs) begin
                    shreg_n = shreg << 4;
                    nib_n   = nib_cnt + 8'd1;
                    if (abt)
                        state_n = FINISH;
                    else if (last_nib) begin
                        nib_n   = 8'd0;
                        line_n  = line_cnt + 8'd1;
                        state_n = (line_full || fifo_empty) ? EOL : SEP;
                    end
                end
            end
            SEP: if (hs) state_n = abt ? FINISH : FETCH;
`ifdef DUMP_CHECKSUM_EN
            STAR: begin
                if (hs) begin
                    shreg_n = acc;
                    nib_n   = 8'd0;
                    state_n = abt ? FINISH : CHK;
                end
            end
            CHK: begin
                if (hs) begin
                    shreg_n = shreg << 4;
                    nib_n   = nib_cnt + 8'd1;
                    if (abt)
                        state_n = FINISH;
                    else if (last_nib) begin
                        nib_n   = 8'd0;
                        state_n = CR;
                    end
                end
            end
`endif
            CR: if (hs) state_n = abt ? FINISH : LF;
            LF: begin
                if (hs) begin
                    line_n = 8'd0;
`ifdef DUMP_CHECKSUM_EN
                    acc_n  = '0;
`endif
                    state_n = (abt || fifo_empty) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                state_n = IDLE;
                pend_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase

        // outputs are registered from the state being entered
        valid_n = 1'b1;
        data_n  = 8'h00;
        unique case (state_n)
            HEX, CHK: data_n  = hex_char(shreg_n[SAMPLE_W-1 -: 4]);
            SEP:      data_n  = 8'h20;
            STAR:     data_n  = 8'h2A;
            CR:       data_n  = 8'h0D;
            LF:       data_n  = 8'h0A;
            default:  valid_n = 1'b0;
        endcase
        busy_n = (state_n != IDLE) && (state_n != FINISH);
        done_n = (state_n == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            nib_cnt    <= 8'd0;
            line_cnt   <= 8'd0;
            sent       <= 1'b0;
            abort_pend <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc        <= '0;
`endif
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            nib_cnt    <= nib_n;
            line_cnt   <= line_n;
            sent       <= sent_n;
            abort_pend <= pend_n;
            tx_valid   <= valid_n;
            tx_data    <= data_n;
            busy       <= busy_n;
            done       <= done_n;
`ifdef DUMP_CHECKSUM_EN
            acc        <= acc_n;
`endif
        end
    end

endmodule
